// File: rtl/serial_adder_sub_if.sv
// Start/busy/done handshake and operand/result bundle
// for the bit-serial adder/subtractor.
interface serial_adder_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (
        output start, sub, a, b, cin,
        input  sum, cout, ovf, busy, done
    );

    modport slave (
        input  start, sub, a, b, cin,
        output sum, cout, ovf, busy, done
    );
endinterface

// File: rtl/serial_adder_sub.sv
// Bit-serial adder/subtractor: one full-adder cell and a
// carry FF reused over WIDTH cycles, LSB first.
module serial_adder_sub #(
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          rst_n,
    serial_adder_sub_if.slave bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_nx;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             cmsb;
    logic             cout_q;
    logic             fa_s;
    logic             fa_c;
    logic             last;
    logic             load;

    // The single full-adder cell
    always_comb begin
        fa_s = a_sr[0] ^ b_sr[0] ^ carry;
        fa_c = (a_sr[0] & b_sr[0])
             | (carry & (a_sr[0] ^ b_sr[0]));
        last = (cnt == CW'(WIDTH - 1));
        r_nx = r_sr >> 1;
        r_nx[WIDTH-1] = fa_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            r_sr   <= '0;
            sum_q  <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            cmsb   <= 1'b0;
            cout_q <= 1'b0;
        end else if (load) begin
            a_sr  <= bus.a;
            b_sr  <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub ? 1'b1 : bus.cin;
            r_sr  <= '0;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            r_sr  <= r_nx;
            carry <= fa_c;
            cnt   <= cnt + CW'(1);
            // carry still holds the carry into the MSB here
            if (last) begin
                sum_q  <= r_nx;
                cout_q <= fa_c;
                cmsb   <= carry;
            end
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = cmsb ^ cout_q;
    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);

endmodule

// File: tb/tb_serial_adder_sub.sv
// Scoreboard bench for serial_adder_sub at WIDTH=8 and WIDTH=1.
// Expected results are queued at issue and popped on done.
module tb_serial_adder_sub;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_adder_sub_if #(.WIDTH(8)) m8();
    serial_adder_sub_if #(.WIDTH(1)) m1();

    serial_adder_sub #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .bus(m8)
    );
    serial_adder_sub #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(m1)
    );

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } res8_t;

    res8_t      q8[$];
    logic [2:0] q1[$];
    int checks = 0;
    int failures = 0;

    function automatic res8_t model8(
        input logic [7:0] a, b, input logic cin, sub
    );
        logic [7:0] bb;
        logic [8:0] full;
        res8_t r;
        bb = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + 9'(sub ? 1'b1 : cin);
        r.sum = full[7:0];
        r.cout = full[8];
        r.ovf = (a[7] == bb[7]) && (full[7] != a[7]);
        return r;
    endfunction

    task automatic issue8(
        input logic [7:0] a, b, input logic cin, sub,
        input res8_t exp
    );
        @(negedge clk);
        m8.start = 1'b1; m8.a = a; m8.b = b;
        m8.cin = cin; m8.sub = sub;
        q8.push_back(exp);
        @(negedge clk);
        m8.start = 1'b0;
        m8.a = 8'($urandom); m8.b = 8'($urandom);
        m8.cin = 1'($urandom); m8.sub = 1'($urandom);
    endtask

    task automatic wait8(
        output bit ok, output int cyc,
        output int bn, output bit st
    );
        logic [9:0] s0;
        s0 = {m8.sum, m8.cout, m8.ovf};
        ok = 0; cyc = 0; bn = 0; st = 1;
        while (!ok && cyc < 40) begin
            if (m8.done === 1'b1) begin
                ok = 1;
            end else begin
                if (m8.busy === 1'b1) bn++;
                if ({m8.sum, m8.cout, m8.ovf} !== s0) st = 0;
                @(negedge clk);
                cyc++;
            end
        end
    endtask

    task automatic test_reset();
        m8.start = 0; m8.sub = 0; m8.cin = 0; m8.a = 0; m8.b = 0;
        m1.start = 0; m1.sub = 0; m1.cin = 0; m1.a = 0; m1.b = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({m8.sum, m8.cout, m8.ovf, m8.busy, m8.done} !== 12'h0) begin
            failures++;
            $display("FAIL reset8 got sum=%h cout=%b ovf=%b busy=%b done=%b want all 0",
                     m8.sum, m8.cout, m8.ovf, m8.busy, m8.done);
        end
        checks++;
        if ({m1.sum, m1.cout, m1.ovf, m1.busy, m1.done} !== 5'h0) begin
            failures++;
            $display("FAIL reset1 got %b want 00000",
                     {m1.sum, m1.cout, m1.ovf, m1.busy, m1.done});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        logic [7:0] va[0:2] = '{8'h0F, 8'hFF, 8'h7F};
        logic [7:0] vb[0:2] = '{8'h01, 8'h01, 8'h00};
        logic       vc[0:2] = '{1'b0, 1'b0, 1'b1};
        logic [9:0] ve[0:2] = '{{8'h10, 2'b00}, {8'h00, 2'b10}, {8'h80, 2'b01}};
        logic [7:0] a, b;
        logic c;
        res8_t e, r;
        bit ok, st;
        int cyc, bn;
        for (int i = 0; i < 7; i++) begin
            if (i < 3) begin
                a = va[i]; b = vb[i]; c = vc[i]; e = ve[i];
            end else begin
                a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
                e = model8(a, b, c, 1'b0);
            end
            issue8(a, b, c, 1'b0, e);
            wait8(ok, cyc, bn, st);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL add_timeout[%0d] no done in %0d cycles", i, cyc);
            end else begin
                r = q8.pop_front();
                checks++;
                if ({m8.sum, m8.cout, m8.ovf} !== r) begin
                    failures++;
                    $display("FAIL add_result[%0d] %h+%h+%b got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                             i, a, b, c, m8.sum, m8.cout, m8.ovf, r.sum, r.cout, r.ovf);
                end
                checks++;
                if (cyc != 8 || bn != 8) begin
                    failures++;
                    $display("FAIL add_latency[%0d] got done@%0d busy=%0d want 8/8", i, cyc, bn);
                end
                checks++;
                if (!st) begin
                    failures++;
                    $display("FAIL add_stable[%0d] outputs changed during RUN want held", i);
                end
            end
            @(negedge clk);
            checks++;
            if (m8.done !== 1'b0 || m8.busy !== 1'b0) begin
                failures++;
                $display("FAIL add_pulse[%0d] got done=%b busy=%b want 0 0", i, m8.done, m8.busy);
            end
        end
    endtask

    task automatic test_sub();
        logic [7:0] va[0:1] = '{8'h05, 8'h80};
        logic [7:0] vb[0:1] = '{8'h07, 8'h01};
        logic [9:0] ve[0:1] = '{{8'hFE, 2'b00}, {8'h7F, 2'b11}};
        logic [7:0] a, b;
        res8_t e, r;
        bit ok, st;
        int cyc, bn;
        for (int i = 0; i < 6; i++) begin
            if (i < 2) begin
                a = va[i]; b = vb[i]; e = ve[i];
            end else begin
                a = 8'($urandom); b = 8'($urandom);
                e = model8(a, b, 1'b0, 1'b1);
            end
            // cin must be ignored in subtract mode
            issue8(a, b, 1'($urandom), 1'b1, e);
            wait8(ok, cyc, bn, st);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL sub_timeout[%0d] no done in %0d cycles", i, cyc);
            end else begin
                r = q8.pop_front();
                checks++;
                if ({m8.sum, m8.cout, m8.ovf} !== r) begin
                    failures++;
                    $display("FAIL sub_result[%0d] %h-%h got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                             i, a, b, m8.sum, m8.cout, m8.ovf, r.sum, r.cout, r.ovf);
                end
                checks++;
                if (cyc != 8 || !st) begin
                    failures++;
                    $display("FAIL sub_timing[%0d] got done@%0d stable=%b want 8 1", i, cyc, st);
                end
            end
        end
    endtask

    task automatic test_start_in_run();
        res8_t r;
        bit ok, st;
        int cyc, bn;
        issue8(8'h21, 8'h13, 1'b0, 1'b0, {8'h34, 2'b00});
        repeat (2) @(negedge clk);
        m8.start = 1'b1; m8.a = 8'hAA; m8.b = 8'h55; m8.sub = 1'b1;
        @(negedge clk);
        m8.start = 1'b0;
        wait8(ok, cyc, bn, st);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL run_start_timeout no done in %0d cycles", cyc);
        end else begin
            r = q8.pop_front();
            checks++;
            if ({m8.sum, m8.cout, m8.ovf} !== r || cyc != 5) begin
                failures++;
                $display("FAIL run_start got sum=%h cout=%b ovf=%b at +%0d want sum=%h cout=%b ovf=%b at +5",
                         m8.sum, m8.cout, m8.ovf, cyc, r.sum, r.cout, r.ovf);
            end
        end
        @(negedge clk);
        checks++;
        if (m8.busy !== 1'b0) begin
            failures++;
            $display("FAIL run_start_restart got busy=%b want 0", m8.busy);
        end
    endtask

    task automatic test_back_to_back();
        res8_t r;
        bit ok, st;
        int cyc, bn;
        issue8(8'hC0, 8'h50, 1'b1, 1'b0, model8(8'hC0, 8'h50, 1'b1, 1'b0));
        wait8(ok, cyc, bn, st);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL b2b_first_timeout no done in %0d cycles", cyc);
        end else begin
            m8.start = 1'b1; m8.a = 8'h12; m8.b = 8'h34;
            m8.cin = 1'b0; m8.sub = 1'b0;
            q8.push_back({8'h46, 2'b00});
            r = q8.pop_front();
            checks++;
            if ({m8.sum, m8.cout, m8.ovf} !== r) begin
                failures++;
                $display("FAIL b2b_first got %h/%b/%b want %h/%b/%b",
                         m8.sum, m8.cout, m8.ovf, r.sum, r.cout, r.ovf);
            end
            @(negedge clk);
            m8.start = 1'b0;
            checks++;
            if (m8.busy !== 1'b1) begin
                failures++;
                $display("FAIL b2b_accept got busy=%b want 1", m8.busy);
            end
            wait8(ok, cyc, bn, st);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL b2b_second_timeout no done in %0d cycles", cyc);
            end else begin
                r = q8.pop_front();
                checks++;
                if ({m8.sum, m8.cout, m8.ovf} !== r || cyc != 8) begin
                    failures++;
                    $display("FAIL b2b_second got %h/%b/%b at +%0d want %h/%b/%b at +8",
                             m8.sum, m8.cout, m8.ovf, cyc, r.sum, r.cout, r.ovf);
                end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        res8_t r;
        bit ok, st, quiet;
        int cyc, bn;
        @(negedge clk);
        m8.start = 1'b1; m8.a = 8'h99; m8.b = 8'h77; m8.cin = 1'b1; m8.sub = 1'b0;
        @(negedge clk);
        m8.start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (m8.busy !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre got busy=%b want 1", m8.busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({m8.sum, m8.cout, m8.ovf, m8.busy, m8.done} !== 12'h0) begin
            failures++;
            $display("FAIL midrst_async got sum=%h cout=%b ovf=%b busy=%b done=%b want all 0",
                     m8.sum, m8.cout, m8.ovf, m8.busy, m8.done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1;
        repeat (12) begin
            @(negedge clk);
            if (m8.done !== 1'b0 || m8.sum !== 8'h00) quiet = 0;
        end
        checks++;
        if (!quiet) begin
            failures++;
            $display("FAIL midrst_abort got done/sum activity after reset want none");
        end
        issue8(8'h03, 8'h04, 1'b0, 1'b0, {8'h07, 2'b00});
        wait8(ok, cyc, bn, st);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL midrst_fresh_timeout no done in %0d cycles", cyc);
        end else begin
            r = q8.pop_front();
            checks++;
            if ({m8.sum, m8.cout, m8.ovf} !== r) begin
                failures++;
                $display("FAIL midrst_fresh got %h/%b/%b want %h/%b/%b",
                         m8.sum, m8.cout, m8.ovf, r.sum, r.cout, r.ovf);
            end
        end
    endtask

    task automatic test_width1();
        logic [1:0] t;
        logic [2:0] e, r;
        int cyc;
        for (int i = 0; i < 8; i++) begin
            t = 2'(i[2]) + 2'(i[1]) + 2'(i[0]);
            // {sum, cout, ovf}; carry into MSB is the loaded cin
            e = {t[0], t[1], t[1] ^ i[0]};
            @(negedge clk);
            m1.start = 1'b1; m1.sub = 1'b0;
            m1.a = i[2]; m1.b = i[1]; m1.cin = i[0];
            q1.push_back(e);
            @(negedge clk);
            m1.start = 1'b0;
            cyc = 0;
            while (m1.done !== 1'b1 && cyc < 10) begin
                @(negedge clk);
                cyc++;
            end
            checks++;
            if (m1.done !== 1'b1) begin
                failures++;
                $display("FAIL w1_timeout[%0d] no done in %0d cycles", i, cyc);
            end else begin
                r = q1.pop_front();
                checks++;
                if ({m1.sum, m1.cout, m1.ovf} !== r || cyc != 1) begin
                    failures++;
                    $display("FAIL w1_fa[%0d] got sum,cout,ovf=%b at +%0d want %b at +1",
                             i, {m1.sum, m1.cout, m1.ovf}, cyc, r);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_start_in_run();
        test_back_to_back();
        test_reset_mid_run();
        test_width1();
        checks++;
        if (q8.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d/%0d pending want 0/0",
                     q8.size(), q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
